control_sequencer: RTL

- Hardwired control unit for the bus-based 32-bit datapath.
- Moore FSM: drives every bus-out, register-in, ALU and memory strobe the datapath consumes, stepping through fetch and execute T-states.
- Decodes the IR opcode field.
- Holds memory strobes against a MemReady handshake.

---
 rtl/control_sequencer_if.sv | 36 +++
 rtl/control_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - control bundle between the sequencer and the 32-bit datapath
interface control_sequencer_if #(
  parameter int OPW = 5
);
  // datapath status into the sequencer
  logic [OPW-1:0] Opcode;
  logic           MemReady;
  logic           Stop;

  // bus drive selects
  logic PCout, Zlowout, Zhighout, MDRout, Cout, BAout;
  // register loads
  logic MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
  // register-select decode strobes
  logic Gra, Grb, Grc, Rin, Rout;
  // PC increment and memory strobes
  logic IncPC, Read, Write;
  logic [OPW-1:0] CONTROL;
  logic           Run;

  modport master (
    input  Opcode, MemReady, Stop,
    output PCout, Zlowout, Zhighout, MDRout, Cout, BAout,
    output MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
    output Gra, Grb, Grc, Rin, Rout,
    output IncPC, Read, Write, CONTROL, Run
  );

  modport slave (
    output Opcode, MemReady, Stop,
    input  PCout, Zlowout, Zhighout, MDRout, Cout, BAout,
    input  MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
    input  Gra, Grb, Grc, Rin, Rout,
    input  IncPC, Read, Write, CONTROL, Run
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control sequencer for the bus-based 32-bit datapath
module control_sequencer #(
  parameter int             OPW    = 5,
  parameter logic [OPW-1:0] ADD_OP = 5'b00011
) (
  input  logic                Clock,
  input  logic                Clear,
  control_sequencer_if.master bus
);

  // Each instruction class gets its own T5..T8 states so later steps need no re-decode.
  localparam logic [4:0] S_RST  = 5'd0;
  localparam logic [4:0] S_T0   = 5'd1;
  localparam logic [4:0] S_T1   = 5'd2;
  localparam logic [4:0] S_T2   = 5'd3;
  localparam logic [4:0] S_T3   = 5'd4;
  localparam logic [4:0] S_T4   = 5'd5;
  localparam logic [4:0] S_HALT = 5'd6;
  localparam logic [4:0] S_ALU5 = 5'd7;
  localparam logic [4:0] S_ALU6 = 5'd8;
  localparam logic [4:0] S_MD5  = 5'd9;
  localparam logic [4:0] S_MD6  = 5'd10;
  localparam logic [4:0] S_MD7  = 5'd11;
  localparam logic [4:0] S_AI5  = 5'd12;
  localparam logic [4:0] S_AI6  = 5'd13;
  localparam logic [4:0] S_LD5  = 5'd14;
  localparam logic [4:0] S_LD6  = 5'd15;
  localparam logic [4:0] S_LD7  = 5'd16;
  localparam logic [4:0] S_LD8  = 5'd17;
  localparam logic [4:0] S_ST5  = 5'd18;
  localparam logic [4:0] S_ST6  = 5'd19;
  localparam logic [4:0] S_ST7  = 5'd20;
  localparam logic [4:0] S_ST8  = 5'd21;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  logic [4:0]     state;
  logic [4:0]     nxt;
  logic [4:0]     boundary;
  logic [OPW-1:0] op_q;
  logic           op_alu, op_md, op_addi, op_ld, op_st, op_halt;

  // Opcode class decode; only consumed while in T4.
  always_comb begin
    op_alu  = (bus.Opcode == OP_ADD) || (bus.Opcode == OP_SUB) ||
              (bus.Opcode == OP_AND) || (bus.Opcode == OP_OR);
    op_md   = (bus.Opcode == OP_MUL) || (bus.Opcode == OP_DIV);
    op_addi = (bus.Opcode == OP_ADDI);
    op_ld   = (bus.Opcode == OP_LD);
    op_st   = (bus.Opcode == OP_ST);
    op_halt = (bus.Opcode == OP_HALT);
  end

  // Next-state logic; every instruction end goes through the Stop check.
  always_comb begin
    boundary = bus.Stop ? S_HALT : S_T0;
    nxt      = state;
    case (state)
      S_RST:  nxt = S_T0;
      S_T0:   nxt = S_T1;
      S_T1:   nxt = S_T2;
      S_T2:   nxt = bus.MemReady ? S_T3 : S_T2;
      S_T3:   nxt = S_T4;
      S_T4: begin
        if (op_alu)       nxt = S_ALU5;
        else if (op_md)   nxt = S_MD5;
        else if (op_addi) nxt = S_AI5;
        else if (op_ld)   nxt = S_LD5;
        else if (op_st)   nxt = S_ST5;
        else if (op_halt) nxt = S_HALT;
        else              nxt = boundary;
      end
      S_HALT: nxt = S_HALT;
      S_ALU5: nxt = S_ALU6;
      S_ALU6: nxt = boundary;
      S_MD5:  nxt = S_MD6;
      S_MD6:  nxt = S_MD7;
      S_MD7:  nxt = boundary;
      S_AI5:  nxt = S_AI6;
      S_AI6:  nxt = boundary;
      S_LD5:  nxt = S_LD6;
      S_LD6:  nxt = S_LD7;
      S_LD7:  nxt = bus.MemReady ? S_LD8 : S_LD7;
      S_LD8:  nxt = boundary;
      S_ST5:  nxt = S_ST6;
      S_ST6:  nxt = S_ST7;
      S_ST7:  nxt = S_ST8;
      S_ST8:  nxt = bus.MemReady ? boundary : S_ST8;
      default: nxt = S_RST;
    endcase
  end

  // State register plus the opcode captured on leaving T4 for the T5 ALU code.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state <= S_RST;
      op_q  <= '0;
    end else begin
      state <= nxt;
      if (state == S_T4) op_q <= bus.Opcode;
    end
  end

  // Moore output decode; T4 also looks at the IR opcode, which is stable throughout T4.
  always_comb begin
    bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.Zhighout = 1'b0;
    bus.MDRout = 1'b0; bus.Cout = 1'b0; bus.BAout = 1'b0;
    bus.MARin = 1'b0; bus.PCin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0;
    bus.Yin = 1'b0; bus.Zin = 1'b0; bus.HIin = 1'b0; bus.LOin = 1'b0;
    bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0;
    bus.IncPC = 1'b0; bus.Read = 1'b0; bus.Write = 1'b0;
    bus.CONTROL = '0;
    bus.Run = (state != S_RST) && (state != S_HALT);
    case (state)
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1;
      end
      S_T2: begin
        bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      S_T3: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      S_T4: begin
        if (op_alu || op_addi) begin
          bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (op_md) begin
          bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
        end else if (op_ld || op_st) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
        end
      end
      S_ALU5: begin
        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.CONTROL = op_q;
      end
      S_ALU6, S_AI6: begin
        bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
      end
      S_MD5: begin
        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.CONTROL = op_q;
      end
      S_MD6: begin
        bus.Zlowout = 1'b1; bus.LOin = 1'b1;
      end
      S_MD7: begin
        bus.Zhighout = 1'b1; bus.HIin = 1'b1;
      end
      S_AI5, S_LD5, S_ST5: begin
        bus.Cout = 1'b1; bus.Zin = 1'b1; bus.CONTROL = ADD_OP;
      end
      S_LD6, S_ST6: begin
        bus.Zlowout = 1'b1; bus.MARin = 1'b1;
      end
      S_LD7: begin
        bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      S_LD8: begin
        bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
      end
      S_ST7: begin
        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
      end
      S_ST8: begin
        bus.Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
